// File: rtl/dot_seq_ctrl_if.sv
// Command, operand-beat, MAC and result signals of the dot-product sequencer.
// slave = sequencer side, master = environment side.
interface dot_seq_ctrl_if #(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_a;
  logic [31:0]          in_b;
  logic [7:0]           mac_dataa_0;
  logic [7:0]           mac_dataa_1;
  logic [7:0]           mac_dataa_2;
  logic [7:0]           mac_dataa_3;
  logic [7:0]           mac_datab_0;
  logic [7:0]           mac_datab_1;
  logic [7:0]           mac_datab_2;
  logic [7:0]           mac_datab_3;
  logic [17:0]          mac_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_result;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_a, in_b, mac_result, out_ready,
    output cmd_ready, in_ready, out_valid, out_result, busy,
    output mac_dataa_0, mac_dataa_1, mac_dataa_2, mac_dataa_3,
    output mac_datab_0, mac_datab_1, mac_datab_2, mac_datab_3
  );

  modport master (
    output cmd_valid, cmd_len, in_valid, in_a, in_b, mac_result, out_ready,
    input  cmd_ready, in_ready, out_valid, out_result, busy,
    input  mac_dataa_0, mac_dataa_1, mac_dataa_2, mac_dataa_3,
    input  mac_datab_0, mac_datab_1, mac_datab_2, mac_datab_3
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Sequences 4-lane int8 beats through an external pipelined MAC and
// accumulates the returned lane sums into one signed dot product.
module dot_seq_ctrl #(
  parameter int MAC_LATENCY = 2,
  parameter int ACC_WIDTH   = 32,
  parameter int LEN_WIDTH   = 8
) (
  input logic           clock0,
  input logic           reset,
  dot_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int SR_W = MAC_LATENCY + 1;

  state_t               state_reg;
  logic [LEN_WIDTH-1:0] remaining_reg;
  logic [SR_W-1:0]      issue_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic [31:0]          mac_a_reg;
  logic [31:0]          mac_b_reg;
  logic                 cmd_ready_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;
  logic                 busy_reg;

  logic                 cmd_fire;
  logic                 in_fire;
  logic                 acc_en;
  logic                 last_drain;
  logic signed [17:0]   mac_s;
  logic [ACC_WIDTH-1:0] mac_ext;

  assign cmd_fire = bus.cmd_valid && cmd_ready_reg;
  assign in_fire  = bus.in_valid && in_ready_reg;
  assign acc_en   = issue_reg[SR_W-1];
  // Only the tail bit set means the beat being accumulated now is the last one in flight.
  assign last_drain = (issue_reg == (SR_W'(1) << MAC_LATENCY));
  assign mac_s    = bus.mac_result;
  assign mac_ext  = ACC_WIDTH'(mac_s);

  always_ff @(posedge clock0) begin
    if (reset) begin
      mac_a_reg <= '0;
      mac_b_reg <= '0;
    end else if (in_fire) begin
      mac_a_reg <= bus.in_a;
      mac_b_reg <= bus.in_b;
    end
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      issue_reg     <= '0;
      acc_reg       <= '0;
      cmd_ready_reg <= 1'b1;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      issue_reg <= (issue_reg << 1) | SR_W'(in_fire);
      if (acc_en) begin
        acc_reg <= acc_reg + mac_ext;
      end
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            remaining_reg <= bus.cmd_len;
            acc_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (bus.cmd_len != '0) begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b1;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            remaining_reg <= remaining_reg - LEN_WIDTH'(1);
            if (remaining_reg == LEN_WIDTH'(1)) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (last_drain) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_reg;
  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_result  = acc_reg;
  assign bus.busy        = busy_reg;
  assign bus.mac_dataa_0 = mac_a_reg[7:0];
  assign bus.mac_dataa_1 = mac_a_reg[15:8];
  assign bus.mac_dataa_2 = mac_a_reg[23:16];
  assign bus.mac_dataa_3 = mac_a_reg[31:24];
  assign bus.mac_datab_0 = mac_b_reg[7:0];
  assign bus.mac_datab_1 = mac_b_reg[15:8];
  assign bus.mac_datab_2 = mac_b_reg[23:16];
  assign bus.mac_datab_3 = mac_b_reg[31:24];
endmodule

// File: doc/dot_seq_ctrl.md
DOT_SEQ_CTRL -- requirements
Module: dot_seq_ctrl

Interface
REQ-001 Parameter MAC_LATENCY, default 2: clock cycles from the MAC operand inputs being sampled to the corresponding mac_result being valid.
REQ-002 Parameter ACC_WIDTH, default 32: accumulator and result width.
REQ-003 Parameter LEN_WIDTH, default 8: width of the beat-count field.
REQ-004 Port clock0, input, 1: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1: a dot-product command is offered.
REQ-007 Port cmd_ready, output, 1: the command is accepted this cycle.
REQ-008 Port cmd_len, input, LEN_WIDTH: number of 4-lane beats in the dot product.
REQ-009 Port in_valid, input, 1: an operand beat is offered.
REQ-010 Port in_ready, output, 1: the operand beat is accepted this cycle.
REQ-011 Port in_a, input, 32: signed 8-bit lanes; lane i occupies bits [8i+7:8i].
REQ-012 Port in_b, input, 32: signed 8-bit lanes, same packing as in_a.
REQ-013 Ports mac_dataa_0..3 and mac_datab_0..3, output, 8 each: registered operands to the external 4-lane MAC.
REQ-014 Port mac_result, input, 18: signed sum of the four lane products, valid MAC_LATENCY cycles after the operands.
REQ-015 Port out_valid, output, 1: out_result holds a completed dot product.
REQ-016 Port out_ready, input, 1: the consumer accepts the result.
REQ-017 Port out_result, output, ACC_WIDTH: signed accumulated dot product.
REQ-018 Port busy, output, 1: high in every state except IDLE.

Function
REQ-019 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-020 In IDLE: cmd_ready=1; on cmd handshake, latch cmd_len into the remaining-beat counter and clear the accumulator; go to RUN if cmd_len>0, else go to DONE with out_result=0.
REQ-021 In RUN: in_ready=1 while remaining>0; each in handshake registers the in_a/in_b lanes onto mac_data*, decrements remaining, and pushes a 1 into a MAC_LATENCY+1 deep issue-valid shift register (0 is pushed on cycles with no handshake).
REQ-022 On the edge accepting the last beat, the FSM SHALL go to DRAIN; in_ready=0 in IDLE, DRAIN and DONE.
REQ-023 When the issue-valid shift register's tail bit is 1 at an edge, acc SHALL become acc + sign_extend(mac_result) modulo 2^ACC_WIDTH; overflow wraps with no saturation or flag.
REQ-024 A beat accepted at edge k SHALL be accumulated at edge k+MAC_LATENCY+1.
REQ-025 DRAIN SHALL go to DONE on the edge that accumulates the last beat; out_valid rises in the following cycle.
REQ-026 In DONE: out_valid=1 and out_result=acc, held stable until out_ready=1; on the handshake edge go to IDLE.
REQ-027 cmd_ready=0 in DONE; a new command can be accepted at the earliest in the cycle after the output handshake.
REQ-028 Gaps in in_valid SHALL be tolerated; the issue-valid shift register tracks beats irrespective of spacing.
REQ-029 mac_data* SHALL hold their last value when no beat is issued; results for non-issued cycles are ignored.
REQ-030 cmd_valid/in_valid asserted in states where the corresponding ready=0 SHALL have no effect.

Reset
REQ-031 While reset=1 at an edge, the block SHALL enter IDLE, clear acc, remaining, the issue-valid register and mac_data*, and drive out_valid=0, out_result=0, busy=0, in_ready=0.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; mac_result values returned after reset are never accumulated.
REQ-033 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (bench models the MAC as an 18-bit signed 4-lane sum with a MAC_LATENCY=2 delay line)
REQ-034 cmd_len=1; in_a=in_b=0x01010101 -> out_result=4; out_valid rises 4 cycles after the beat-accept edge.
REQ-035 cmd_len=3; back-to-back beats with all lanes 0x7F x 0x7F -> out_result=193548 (0x0002F40C).
REQ-036 cmd_len=1; in_a=0x80808080, in_b=0x7F7F7F7F -> out_result=0xFFFF0200 (-65024).
REQ-037 cmd_len=4 with in_valid low for 2 cycles between beats, all lanes 1x1; out_ready held low 5 cycles -> out_result=16, held stable, single handshake.
REQ-038 cmd_len=0 -> out_valid one cycle after cmd accept with out_result=0, and no beats are consumed.
REQ-039 Reset asserted after 2 of 5 beats -> IDLE and busy=0 next cycle; a fresh cmd_len=1 with lanes 1x1 -> out_result=4, with no stale contribution.
